output_arbiter: RTL and testbench

Per-output-port allocator sitting directly downstream of the five LBDR routing units of a router. It collects the request bit for its own output direction from each input port's LBDR, grants the output to one input with round-robin fairness, and holds that grant for the whole packet (header through tail). It gates every flit transfer on a credit counter that tracks free slots in the downstream input FIFO. One instance exists per output port (N, E, W, S, L).

---
 rtl/output_arbiter_pkg.sv | 23 ++
 rtl/output_arbiter_rr_picker.sv | 38 +++
 rtl/output_arbiter.sv | 116 +++++++++++
 tb/tb_output_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_arbiter_pkg.sv
// Shared definitions for the per-output-port arbiter.
//   - Port index constants (L, N, E, W, S) used by the LBDR request vector.
//   - Arbiter state encoding.
//   - Default downstream FIFO depth, shared with the input buffer.
package output_arbiter_pkg;

  localparam int NPORTS  = 5;
  localparam int IDX_W   = 3;

  localparam logic [IDX_W-1:0] PORT_L = 3'd0;
  localparam logic [IDX_W-1:0] PORT_N = 3'd1;
  localparam logic [IDX_W-1:0] PORT_E = 3'd2;
  localparam logic [IDX_W-1:0] PORT_W = 3'd3;
  localparam logic [IDX_W-1:0] PORT_S = 3'd4;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/output_arbiter_rr_picker.sv
// rr_picker: combinational rotating priority encoder.
// Searches req starting at index (last+1) mod 5 and returns the first hit.
//   req      [4:0] request vector (0=L, 1=N, 2=E, 3=W, 4=S)
//   last     [2:0] index of the most recently served input
//   pick     [4:0] one-hot winner, zero when nothing requests
//   pick_idx [2:0] binary index of the winner, zero when nothing requests
//   any            at least one request present
module rr_picker
  import output_arbiter_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NPORTS-1:0] pick,
  output logic [IDX_W-1:0]  pick_idx,
  output logic              any
);

  logic [3:0] cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      // last+k is at most 7+5=12, so two conditional subtractions reduce it mod 5.
      cand = 4'(last) + 4'(k);
      if (cand >= 4'(NPORTS)) cand = cand - 4'(NPORTS);
      if (cand >= 4'(NPORTS)) cand = cand - 4'(NPORTS);
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                       = 1'b1;
        pick_idx                  = cand[IDX_W-1:0];
        pick[cand[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// output_arbiter: allocator for one router output port.
// Grants the output to one input LBDR with round-robin fairness, holds the
// grant from header to tail, and gates each flit on a credit counter that
// mirrors free slots in the downstream input FIFO.
//   clk        router clock
//   rst        asynchronous active-high reset
//   req  [4:0] per-input request bits for this output (0=L,1=N,2=E,3=W,4=S)
//   tail [4:0] head flit of input i is a tail flit
//   credit_in  one-cycle pulse: one downstream FIFO slot freed
//   grant[4:0] registered one-hot owner of the output, zero when idle
//   sel  [2:0] registered crossbar select, binary index of grant
//   xfer       combinational flit-move strobe (also granted FIFO read)
//   credits    current free-slot count
module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] tail,
  input  logic              credit_in,
  output logic [NPORTS-1:0] grant,
  output logic [IDX_W-1:0]  sel,
  output logic              xfer,
  output logic [CW-1:0]     credits
);

  arb_state_t        state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]  sel_q,   sel_d;
  logic [IDX_W-1:0]  last_q,  last_d;
  logic [CW-1:0]     credits_q, credits_d;

  logic [NPORTS-1:0] pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rr_picker u_rr_picker (
    .req      (req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // A flit moves only while owning the output, the owner has data, and
  // downstream has room. Arbitration itself never looks at credits.
  assign xfer = (state_q == BUSY) && req[sel_q] && (credits_q != '0);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          sel_d   = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A dropped req[sel] simply stalls; the packet keeps the output.
        if (xfer && tail[sel_q]) begin
          last_d  = sel_q;
          grant_d = '0;
          sel_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    unique case ({xfer, credit_in})
      2'b10:   credits_d = credits_q - CW'(1);
      // Protocol error at full: hold at DEPTH rather than wrap.
      2'b01:   if (credits_q != CW'(DEPTH)) credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      last_q    <= PORT_S;  // so L is checked first after reset
      credits_q <= CW'(DEPTH);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      credits_q <= credits_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(credit_in && (credits_q == CW'(DEPTH))))
        else $warning("output_arbiter: credit_in received with credit counter already at DEPTH");
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign credits = credits_q;

endmodule

// File: tb/tb_output_arbiter.sv
module tb_output_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       credit_in;
  logic [4:0] grant;
  logic [2:0] sel;
  logic       xfer;
  logic [2:0] credits;

  logic [11:0] st;
  logic [11:0] exp_v;
  int          n_checks;
  int          n_fail;

  output_arbiter #(.DEPTH(4), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tail      (tail),
    .credit_in (credit_in),
    .grant     (grant),
    .sel       (sel),
    .xfer      (xfer),
    .credits   (credits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed status packed as {grant, sel, xfer, credits}.
  assign st = {grant, sel, xfer, credits};

  function automatic logic [11:0] expv(input logic [4:0] g, input logic [2:0] s,
                                       input logic x, input logic [2:0] c);
    return {g, s, x, c};
  endfunction

  // Advance to just after the next falling edge: registers have settled
  // from the preceding rising edge and inputs may be changed safely.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic restore_credits();
    credit_in = 1'b1;
    repeat (3) step();
    credit_in = 1'b0;
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL credits_restored: got %b want %b", st, exp_v); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
    repeat (3) step();
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL reset_hold: got %b want %b", st, exp_v); end
    rst = 1'b0;
    step();
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL reset_release: got %b want %b", st, exp_v); end
  endtask

  task automatic test_single();
    req = 5'b00010; tail = '0;
    #1;
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL single_idle_noxfer: got %b want %b", st, exp_v); end
    step();
    exp_v = expv(5'b00010, 3'd1, 1'b1, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL single_grant: got %b want %b", st, exp_v); end
    step();
    exp_v = expv(5'b00010, 3'd1, 1'b1, 3'd3);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL single_flit2: got %b want %b", st, exp_v); end
    step();
    exp_v = expv(5'b00010, 3'd1, 1'b1, 3'd2);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL single_flit3: got %b want %b", st, exp_v); end
    tail = 5'b00010;
    step();
    req = '0; tail = '0;
    #1;
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd1);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL single_done: got %b want %b", st, exp_v); end
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd2);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL credit_return: got %b want %b", st, exp_v); end
    credit_in = 1'b1;
    repeat (2) step();
    credit_in = 1'b0;
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL credits_full: got %b want %b", st, exp_v); end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [5];
    order[0] = 3'd2; order[1] = 3'd3; order[2] = 3'd4; order[3] = 3'd0; order[4] = 3'd1;
    req = 5'b11111; tail = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_v = expv(5'b00001 << order[i], order[i], 1'b1, 3'd4);
      n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, st, exp_v); end
      // Return a credit alongside each single-flit transfer.
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd4);
      n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL rr_bubble%0d: got %b want %b", i, st, exp_v); end
    end
    req = '0; tail = '0;
  endtask

  task automatic test_credit_stall();
    req = 5'b00001; tail = '0;
    step();
    exp_v = expv(5'b00001, 3'd0, 1'b1, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL stall_grant: got %b want %b", st, exp_v); end
    for (int c = 3; c >= 1; c--) begin
      step();
      exp_v = expv(5'b00001, 3'd0, 1'b1, 3'(c));
      n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL stall_flit_c%0d: got %b want %b", c, st, exp_v); end
    end
    step();
    exp_v = expv(5'b00001, 3'd0, 1'b0, 3'd0);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL stall_empty: got %b want %b", st, exp_v); end
    step();
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL stall_hold: got %b want %b", st, exp_v); end
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    exp_v = expv(5'b00001, 3'd0, 1'b1, 3'd1);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL stall_one_credit: got %b want %b", st, exp_v); end
    step();
    exp_v = expv(5'b00001, 3'd0, 1'b0, 3'd0);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL stall_after_one: got %b want %b", st, exp_v); end
    credit_in = 1'b1;
    step();
    exp_v = expv(5'b00001, 3'd0, 1'b1, 3'd1);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL stall_credit2: got %b want %b", st, exp_v); end
    // Tail flit moves in the same cycle a credit arrives: count unchanged.
    tail = 5'b00001;
    step();
    credit_in = 1'b0; req = '0; tail = '0;
    #1;
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd1);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL stall_simul: got %b want %b", st, exp_v); end
    restore_credits();
  endtask

  task automatic test_bubble();
    req = 5'b00100; tail = '0;
    step();
    exp_v = expv(5'b00100, 3'd2, 1'b1, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL bub_grant: got %b want %b", st, exp_v); end
    step();
    req = 5'b01000;
    #1;
    exp_v = expv(5'b00100, 3'd2, 1'b0, 3'd3);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL bub_drop0: got %b want %b", st, exp_v); end
    for (int i = 1; i < 3; i++) begin
      step();
      n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL bub_drop%0d: got %b want %b", i, st, exp_v); end
    end
    req = 5'b01100; tail = 5'b00100;
    #1;
    exp_v = expv(5'b00100, 3'd2, 1'b1, 3'd3);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL bub_resume: got %b want %b", st, exp_v); end
    step();
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd2);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL bub_release: got %b want %b", st, exp_v); end
    tail = 5'b01000;
    step();
    exp_v = expv(5'b01000, 3'd3, 1'b1, 3'd2);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL bub_next: got %b want %b", st, exp_v); end
    step();
    req = '0; tail = '0;
    #1;
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd1);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL bub_done: got %b want %b", st, exp_v); end
    restore_credits();
  endtask

  task automatic test_reset_mid();
    req = 5'b00010; tail = '0;
    step();
    exp_v = expv(5'b00010, 3'd1, 1'b1, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL rstmid_grant: got %b want %b", st, exp_v); end
    repeat (2) step();
    exp_v = expv(5'b00010, 3'd1, 1'b1, 3'd2);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL rstmid_busy: got %b want %b", st, exp_v); end
    #2 rst = 1'b1;
    #1;
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL rstmid_async: got %b want %b", st, exp_v); end
    req = 5'b10110;
    step();
    rst = 1'b0;
    step();
    exp_v = expv(5'b00010, 3'd1, 1'b1, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL rstmid_first_grant: got %b want %b", st, exp_v); end
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_credit_overflow();
    exp_v = expv(5'b00000, 3'd0, 1'b0, 3'd4);
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL ovf_pre: got %b want %b", st, exp_v); end
    credit_in = 1'b1;
    step();
    credit_in = 1'b0;
    n_checks++; if (st !== exp_v) begin n_fail++; $display("FAIL ovf_saturate: got %b want %b", st, exp_v); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; req = '0; tail = '0; credit_in = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_bubble();
    test_reset_mid();
    test_credit_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
